// File: rtl/fifo_ff_pkg.sv
// Shared definitions for the flop-based FIFO family.
// Read-mode selector used by every variant.
package fifo_ff_pkg;

  typedef enum logic {
    FIFO_RD_REG  = 1'b0,
    FIFO_RD_FWFT = 1'b1
  } fifo_rd_mode_e;

endpackage

// File: rtl/fifo_ff_ptr.sv
// Wrapping pointer for the FIFO storage array.
// Wraps DEPTH-1 -> 0 explicitly so non-power-of-two depths work.
module fifo_ff_ptr #(
  parameter int DEPTH = 16,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [ADDR-1:0] ptr
);

  localparam logic [ADDR-1:0] PTR_LAST = ADDR'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ff_sync_p.sv
// Single-clock flop FIFO with generic depth, REG/FWFT read modes,
// programmable almost thresholds and sticky overflow/underflow flags.
module fifo_ff_sync_p
  import fifo_ff_pkg::*;
#(
  parameter int            WIDTH     = 8,
  parameter int            DEPTH     = 16,
  parameter int            ADDR      = $clog2(DEPTH),
  parameter fifo_rd_mode_e RD_MODE   = FIFO_RD_REG,
  parameter int            AF_THRESH = DEPTH - 2,
  parameter int            AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ADDR:0]    occup,
  output logic             overflow,
  output logic             underflow
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_ff_sync_p: DEPTH must be >= 2");
  end
  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("fifo_ff_sync_p: need AE_THRESH < AF_THRESH <= DEPTH");
  end

  localparam logic [ADDR:0] OCC_FULL = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] OCC_AF   = (ADDR+1)'(AF_THRESH);
  localparam logic [ADDR:0] OCC_AE   = (ADDR+1)'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR-1:0]  wr_ptr;
  logic [ADDR-1:0]  rd_ptr;
  logic [ADDR:0]    occup_p0;
  logic             push;
  logic             pop;

  assign empty        = (occup_p0 == '0);
  assign full         = (occup_p0 == OCC_FULL);
  assign almost_empty = (occup_p0 <= OCC_AE);
  assign almost_full  = (occup_p0 >= OCC_AF);
  assign occup        = occup_p0;

  // A full FIFO still takes a write when the same cycle frees a slot.
  assign pop  = rd_en && !empty;
  assign push = wr_en && (!full || pop);

  fifo_ff_ptr #(.DEPTH(DEPTH), .ADDR(ADDR)) u_wr_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (push),
    .ptr  (wr_ptr)
  );

  fifo_ff_ptr #(.DEPTH(DEPTH), .ADDR(ADDR)) u_rd_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pop),
    .ptr  (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occup_p0 <= '0;
    end else if (push && !pop) begin
      occup_p0 <= occup_p0 + 1'b1;
    end else if (pop && !push) begin
      occup_p0 <= occup_p0 - 1'b1;
    end
  end

  // A fresh error in the clearing cycle takes priority over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !err_clr) || (wr_en && !push);
      underflow <= (underflow && !err_clr) || (rd_en && !pop);
    end
  end

  if (RD_MODE == FIFO_RD_REG) begin : g_rd_reg
    logic [WIDTH-1:0] rd_data_p1;
    logic             rd_valid_p1;

    // Read stage: registered output, one cycle after the accepted pop
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_p1  <= '0;
        rd_valid_p1 <= 1'b0;
      end else begin
        rd_valid_p1 <= pop;
        if (pop) begin
          rd_data_p1 <= mem[rd_ptr];
        end
      end
    end

    assign rd_data  = rd_data_p1;
    assign rd_valid = rd_valid_p1;
  end else begin : g_rd_fwft
    // Storage is never reset, so hide it while empty to present zero.
    assign rd_data  = empty ? '0 : mem[rd_ptr];
    assign rd_valid = !empty;
  end

endmodule

// File: tb/tb_fifo_ff_sync_p.sv
// Bench for fifo_ff_sync_p: REG and FWFT instances (DEPTH=5) driven in
// lockstep and compared against a queue-based reference model.
module tb_fifo_ff_sync_p;
  import fifo_ff_pkg::*;

  localparam int W = 8;
  localparam int D = 5;
  localparam int A = $clog2(D);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] wr_data;
  logic         wr_en, rd_en, err_clr;

  logic [W-1:0] r_rd_data, f_rd_data;
  logic         r_rd_valid, f_rd_valid;
  logic         r_empty, r_full, r_ae, r_af, r_ovf, r_unf;
  logic         f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [A:0]   r_occup, f_occup;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  logic         ovf_m, unf_m, rdv_m;
  logic [W-1:0] rdd_m;

  always #5 clk = ~clk;

  fifo_ff_sync_p #(.WIDTH(W), .DEPTH(D), .RD_MODE(FIFO_RD_REG),
                   .AF_THRESH(3), .AE_THRESH(2)) u_reg (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .rd_en(rd_en), .err_clr(err_clr), .rd_data(r_rd_data),
    .rd_valid(r_rd_valid), .empty(r_empty), .full(r_full),
    .almost_empty(r_ae), .almost_full(r_af), .occup(r_occup),
    .overflow(r_ovf), .underflow(r_unf)
  );

  fifo_ff_sync_p #(.WIDTH(W), .DEPTH(D), .RD_MODE(FIFO_RD_FWFT),
                   .AF_THRESH(3), .AE_THRESH(2)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
    .rd_en(rd_en), .err_clr(err_clr), .rd_data(f_rd_data),
    .rd_valid(f_rd_valid), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .occup(f_occup),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    rdv_m = 1'b0;
    rdd_m = '0;
  endtask

  task automatic model_step(input logic wr, input logic rd, input logic [W-1:0] d,
                            input logic clr);
    bit do_pop, do_push;
    do_pop  = rd && (q.size() > 0);
    do_push = wr && ((q.size() < D) || do_pop);
    rdv_m = do_pop;
    if (do_pop) begin
      rdd_m = q.pop_front();
    end
    if (do_push) begin
      q.push_back(d);
    end
    ovf_m = (ovf_m && !clr) || (wr && !do_push);
    unf_m = (unf_m && !clr) || (rd && !do_pop);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("reg_occup", 32'(r_occup), 32'(n));
    chk("reg_empty", 32'(r_empty), 32'(n == 0));
    chk("reg_full",  32'(r_full),  32'(n == D));
    chk("reg_ae",    32'(r_ae),    32'(n <= 2));
    chk("reg_af",    32'(r_af),    32'(n >= 3));
    chk("reg_ovf",   32'(r_ovf),   32'(ovf_m));
    chk("reg_unf",   32'(r_unf),   32'(unf_m));
    chk("reg_rdv",   32'(r_rd_valid), 32'(rdv_m));
    chk("reg_rdd",   32'(r_rd_data),  32'(rdd_m));
    chk("fwft_occup", 32'(f_occup), 32'(n));
    chk("fwft_empty", 32'(f_empty), 32'(n == 0));
    chk("fwft_full",  32'(f_full),  32'(n == D));
    chk("fwft_ovf",   32'(f_ovf),   32'(ovf_m));
    chk("fwft_unf",   32'(f_unf),   32'(unf_m));
    chk("fwft_rdv",   32'(f_rd_valid), 32'(n > 0));
    chk("fwft_rdd",   32'(f_rd_data),  (n > 0) ? 32'(q[0]) : 32'h0);
  endtask

  task automatic cyc(input logic wr, input logic rd, input logic [W-1:0] d,
                     input logic clr);
    wr_en   = wr;
    rd_en   = rd;
    wr_data = d;
    err_clr = clr;
    @(posedge clk);
    model_step(wr, rd, d, clr);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, overflow attempt, drain
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    cyc(1'b1, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Full with simultaneous push/pop, then drain
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);

    // Empty with simultaneous push/pop, error clear, clear-vs-new-error
    cyc(1'b1, 1'b1, 8'h3C, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Interleaved pairs across the pointer wrap
    cyc(1'b1, 1'b0, 8'h40, 1'b0);
    for (int i = 1; i <= 12; i++) cyc(1'b1, 1'b1, 8'h40 + 8'(i), 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);

    // Asynchronous reset between edges with 3 entries stored
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
    wr_en = 1'b0;
    rd_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with shifting push/pop bias
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 250) % 3;
      cyc(($urandom_range(99) < (bias == 0 ? 70 : (bias == 1 ? 30 : 50))),
          ($urandom_range(99) < (bias == 0 ? 30 : (bias == 1 ? 70 : 50))),
          8'($urandom), ($urandom_range(99) < 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ff_sync_p.md
# fifo_ff_sync_p

Parametrised, flop-based, single-clock FIFO that succeeds the fixed-mode sync FIFO variants. It adds generic (non-power-of-two) depth, a selectable read mode (registered or first-word-fall-through), programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits between any two same-clock producer/consumer blocks in the common library and is exercised by the shared FIFO verification environment.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 16, number of entries (≥2, any integer)
- ADDR, $clog2(DEPTH), pointer width; occupancy is ADDR+1 bits
- RD_MODE, FIFO_RD_REG, read mode from fifo_ff_pkg: FIFO_RD_REG or FIFO_RD_FWFT
- AF_THRESH, DEPTH-2, almost_full asserts when occup ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserts when occup ≤ AE_THRESH

- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_data  input  WIDTH  write data
- wr_en  input  1  push request
- rd_en  input  1  pop request
- err_clr  input  1  synchronous clear of sticky error flags
- rd_data  output  WIDTH  read data (mode-dependent timing)
- rd_valid  output  1  rd_data qualifier
- empty  output  1  occup == 0
- full  output  1  occup == DEPTH
- almost_empty  output  1  occup ≤ AE_THRESH
- almost_full  output  1  occup ≥ AF_THRESH
- occup  output  ADDR+1  current entry count
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

## Operation
- Reset (rst_n low, async): wr/rd pointers 0, occup 0, rd_data 0, rd_valid 0, overflow 0, underflow 0; empty=1, almost_empty=1, full=0, almost_full=0. Storage array not reset.
- Push accepted when wr_en && (!full || pop accepted same cycle); write to mem[wr_ptr], wr_ptr advances.
- Pop accepted when rd_en && !empty; rd_ptr advances.
- Pointers wrap DEPTH-1 → 0 explicitly (no reliance on power-of-two rollover).
- occup: +1 push only, −1 pop only, unchanged on both or neither; never exceeds DEPTH nor drops below 0.
- Full with simultaneous wr_en and rd_en: both accepted, occup stays DEPTH, overflow not set.
- Empty with simultaneous wr_en and rd_en: push accepted, pop rejected, underflow set, occup → 1.
- Rejected push: data dropped, overflow set. Rejected pop: state unchanged, underflow set.
- err_clr clears both flags; a new error in the same cycle as err_clr wins (flag stays/sets to 1).
- FIFO_RD_REG: accepted pop loads mem[rd_ptr] into rd_data register; rd_valid=1 the following cycle only; rd_data holds value otherwise.
- FIFO_RD_FWFT: rd_data = mem[rd_ptr] continuously, rd_valid = !empty; rd_en acknowledges the shown word.

## Timing
- All flags/occup registered-state derived; reflect a push/pop the cycle after the accepting edge.
- Write-to-read latency: data written at edge N is poppable at edge N+1 (empty deasserts after N).
- REG mode read latency 1 cycle (rd_en at edge N → rd_data/rd_valid valid after N, until N+1).
- FWFT mode: first word visible on rd_data after the write edge, zero extra cycles.
- Error flags set at the edge of the offending request.
- Reset mid-operation: all outputs reach reset values immediately on rst_n fall, independent of clk; contents lost.

## Structure
- fifo_ff_pkg: typedef enum fifo_rd_mode_e {FIFO_RD_REG, FIFO_RD_FWFT}; shared with other FIFO variants.
- Sub-module fifo_ff_ptr: wrapping pointer counter (params DEPTH, ADDR; inputs clk, rst_n, inc; output ptr), instantiated for wr and rd.
- Elaboration checks: DEPTH ≥ 2, AE_THRESH < AF_THRESH ≤ DEPTH.

## Test plan
- DEPTH=5, REG: 5 pushes 0x01..0x05 → full=1, occup=5, almost_full=1; 6th push 0xFF → overflow=1, then 5 pops return 0x01..0x05, each one cycle after rd_en.
- DEPTH=5: 12 push/pop pairs interleaved to cross wrap twice → data order preserved, occup never >5.
- Full + simultaneous wr_en/rd_en with 0xAA → occup stays 5, overflow=0, 0xAA appears after existing 4 entries.
- Empty + simultaneous wr_en/rd_en with 0x3C → underflow=1, occup=1, next pop returns 0x3C; err_clr → underflow=0.
- FWFT: push 0x77 at edge N → rd_data=0x77, rd_valid=1 after N without rd_en; rd_en → empty=1 next cycle.
- Fill to 3 entries, assert rst_n low between edges → occup=0, empty=1, rd_valid=0, flags 0 immediately.
